// File: rtl/stage_mem_redirect_pkg.sv
// ---------------------------------------------------------------------------
// stage_mem_redirect_pkg
// Shared definitions for the EX/MEM register and branch/jump resolution block.
//   - Control-bit indices inside the registered control field. These indices
//     do not depend on the opcode.
//   - Default width of the redirect counter.
//   - Bubble value for the control field. It clears Valid/Branch/Bne/Jump.
//   - The packed EX/MEM record and a word-alignment helper for targets.
// ---------------------------------------------------------------------------
package stage_mem_redirect_pkg;

    localparam int CTL_VALID  = 0;
    localparam int CTL_BRANCH = 1;
    localparam int CTL_BNE    = 2;
    localparam int CTL_JUMP   = 3;
    localparam int CTL_W      = 4;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [CTL_W-1:0] CTL_BUBBLE = '0;

    typedef struct packed {
        logic [CTL_W-1:0] ctl;
        logic             zero;
        logic [31:0]      pc;
        logic [31:0]      btarg;
        logic [31:0]      jtarg;
    } ex_mem_t;

    // Redirect targets are always word addresses, so the low two bits are cleared.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/stage_mem_redirect_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// stage_mem_redirect_ex_mem_reg
// The EX/MEM pipeline register. It can be cleared to a bubble and it can hold.
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset; clears every field
//   kill     in   load a bubble into the control field; other fields unchanged
//   hold     in   keep the current contents (ignored while kill is high)
//   ex_in    in   fields presented by the EX stage
//   mem_out  out  registered fields seen by the MEM stage
// ---------------------------------------------------------------------------
module stage_mem_redirect_ex_mem_reg
    import stage_mem_redirect_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    kill,
    input  logic    hold,
    input  ex_mem_t ex_in,
    output ex_mem_t mem_out
);

    ex_mem_t mem_d;
    ex_mem_t mem_q;

    // Kill beats hold. A redirect must squash the wrong-path slot even while the
    // hazard unit is stalling. Otherwise the redirect would fire again next cycle.
    always_comb begin
        mem_d = mem_q;
        if (kill) begin
            mem_d.ctl = CTL_BUBBLE;
        end else if (!hold) begin
            mem_d = ex_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign mem_out = mem_q;

endmodule

// File: rtl/stage_mem_redirect.sv
// ---------------------------------------------------------------------------
// stage_mem_redirect
// This block holds the EX/MEM pipeline register and resolves branches and jumps
// for the 5-stage CPU.
//   Clk, Rst                      clock; asynchronous active-high reset
//   Stall                         hold EX/MEM contents
//   EX_Valid/Branch/Bne/Jump      control bits of the EX instruction
//   EX_Zero, EX_PC                ALU zero flag and PC of the EX instruction
//   EX_Btarg, EX_Jtarg            branch and jump targets
//   MEM_Valid, MEM_PC             registered instruction status and PC
//   MEM_PCSrc, MEM_Btarg_or_Jtarg fetch redirect request and word-aligned target
//   Flush_IFID, Flush_IDEX        squash the two younger pipeline slots
//   Redirect_Count                saturating count of redirect cycles
// ---------------------------------------------------------------------------
module stage_mem_redirect
    import stage_mem_redirect_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             EX_Valid,
    input  logic             EX_Branch,
    input  logic             EX_Bne,
    input  logic             EX_Jump,
    input  logic             EX_Zero,
    input  logic [31:0]      EX_PC,
    input  logic [31:0]      EX_Btarg,
    input  logic [31:0]      EX_Jtarg,
    output logic             MEM_Valid,
    output logic [31:0]      MEM_PC,
    output logic             MEM_PCSrc,
    output logic [31:0]      MEM_Btarg_or_Jtarg,
    output logic             Flush_IFID,
    output logic             Flush_IDEX,
    output logic [CNT_W-1:0] Redirect_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_mem_t          ex_in;
    ex_mem_t          mem_s;
    logic             take;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Pack the EX-side signals into the register record.
    always_comb begin
        ex_in                 = '0;
        ex_in.ctl[CTL_VALID]  = EX_Valid;
        ex_in.ctl[CTL_BRANCH] = EX_Branch;
        ex_in.ctl[CTL_BNE]    = EX_Bne;
        ex_in.ctl[CTL_JUMP]   = EX_Jump;
        ex_in.zero            = EX_Zero;
        ex_in.pc              = EX_PC;
        ex_in.btarg           = EX_Btarg;
        ex_in.jtarg           = EX_Jtarg;
    end

    // A taken redirect kills its own successor slot. This is why MEM_PCSrc lasts
    // only one cycle.
    stage_mem_redirect_ex_mem_reg u_ex_mem_reg (
        .clk     (Clk),
        .rst     (Rst),
        .kill    (take),
        .hold    (Stall),
        .ex_in   (ex_in),
        .mem_out (mem_s)
    );

    // Resolution uses only registered state. A bubble never redirects, even if
    // it still carries stale control bits. Jump takes precedence for the target.
    always_comb begin
        take = mem_s.ctl[CTL_VALID] &
               (mem_s.ctl[CTL_JUMP] |
                (mem_s.ctl[CTL_BRANCH] & mem_s.zero) |
                (mem_s.ctl[CTL_BNE] & ~mem_s.zero));
        target = mem_s.ctl[CTL_JUMP] ? mem_s.jtarg : mem_s.btarg;
    end

    // The redirect counter sticks at all-ones. Only reset clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (take && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign MEM_Valid          = mem_s.ctl[CTL_VALID];
    assign MEM_PC             = mem_s.pc;
    assign MEM_PCSrc          = take;
    assign MEM_Btarg_or_Jtarg = word_align(target);
    assign Flush_IFID         = take;
    assign Flush_IDEX         = take;
    assign Redirect_Count     = cnt_q;

endmodule

// File: tb/tb_stage_mem_redirect.sv
// ---------------------------------------------------------------------------
// tb_stage_mem_redirect
// Scoreboard bench for stage_mem_redirect. There are two instances. One uses
// the default 16-bit counter. The other uses a 2-bit counter so that
// saturation is easy to reach. The stimulus task updates an
// instruction-level reference model and queues the expected outputs. A
// monitor pops that queue after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_stage_mem_redirect;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall;
    logic        EX_Valid, EX_Branch, EX_Bne, EX_Jump, EX_Zero;
    logic [31:0] EX_PC, EX_Btarg, EX_Jtarg;

    logic        mem_valid, mem_pcsrc, flush_ifid, flush_idex;
    logic [31:0] mem_pc, mem_target;
    logic [15:0] redirect_count;

    logic        s_mem_valid, s_mem_pcsrc, s_flush_ifid, s_flush_idex;
    logic [31:0] s_mem_pc, s_mem_target;
    logic [1:0]  s_redirect_count;

    always #5 Clk = ~Clk;

    stage_mem_redirect dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall),
        .EX_Valid(EX_Valid), .EX_Branch(EX_Branch), .EX_Bne(EX_Bne),
        .EX_Jump(EX_Jump), .EX_Zero(EX_Zero), .EX_PC(EX_PC),
        .EX_Btarg(EX_Btarg), .EX_Jtarg(EX_Jtarg),
        .MEM_Valid(mem_valid), .MEM_PC(mem_pc), .MEM_PCSrc(mem_pcsrc),
        .MEM_Btarg_or_Jtarg(mem_target), .Flush_IFID(flush_ifid),
        .Flush_IDEX(flush_idex), .Redirect_Count(redirect_count)
    );

    stage_mem_redirect #(.CNT_W(2)) dut_small (
        .Clk(Clk), .Rst(Rst), .Stall(Stall),
        .EX_Valid(EX_Valid), .EX_Branch(EX_Branch), .EX_Bne(EX_Bne),
        .EX_Jump(EX_Jump), .EX_Zero(EX_Zero), .EX_PC(EX_PC),
        .EX_Btarg(EX_Btarg), .EX_Jtarg(EX_Jtarg),
        .MEM_Valid(s_mem_valid), .MEM_PC(s_mem_pc), .MEM_PCSrc(s_mem_pcsrc),
        .MEM_Btarg_or_Jtarg(s_mem_target), .Flush_IFID(s_flush_ifid),
        .Flush_IDEX(s_flush_idex), .Redirect_Count(s_redirect_count)
    );

    typedef struct {
        bit        valid, branch, bne, jump, zero;
        bit [31:0] pc, btarg, jtarg;
    } instr_t;

    typedef struct {
        bit        valid;
        bit [31:0] pc;
        bit        pcsrc;
        bit [31:0] target;
        int        cnt16;
        int        cnt2;
    } expect_t;

    expect_t sb_q[$];
    instr_t  mem_slot;
    int      cnt16, cnt2;
    int      checks = 0;
    int      failures = 0;

    // Reference rule: an instruction redirects fetch when it is real and is a
    // jump or a taken beq or bne.
    function automatic bit redirects(input instr_t i);
        return i.valid && (i.jump || (i.branch && i.zero) || (i.bne && !i.zero));
    endfunction

    function automatic bit [31:0] dest(input instr_t i);
        bit [31:0] t;
        t = i.jump ? i.jtarg : i.btarg;
        return t - (t % 4);
    endfunction

    function automatic instr_t mk(input bit v, input bit br, input bit bn, input bit j,
                                  input bit z, input bit [31:0] pc,
                                  input bit [31:0] bt, input bit [31:0] jt);
        instr_t i;
        i.valid = v; i.branch = br; i.bne = bn; i.jump = j; i.zero = z;
        i.pc = pc; i.btarg = bt; i.jtarg = jt;
        return i;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mem_slot = mk(0, 0, 0, 0, 0, 0, 0, 0);
        cnt16 = 0;
        cnt2 = 0;
    endtask

    // Called on a falling edge. It drives one EX instruction, advances the
    // model across the coming rising edge, queues the expectation, and then
    // waits for the next falling edge.
    task automatic applyStimulus(input instr_t ins, input bit stall);
        expect_t e;
        Stall = stall;
        EX_Valid = ins.valid; EX_Branch = ins.branch; EX_Bne = ins.bne;
        EX_Jump = ins.jump; EX_Zero = ins.zero; EX_PC = ins.pc;
        EX_Btarg = ins.btarg; EX_Jtarg = ins.jtarg;
        if (redirects(mem_slot)) begin
            cnt16 = (cnt16 < 65535) ? cnt16 + 1 : 65535;
            cnt2  = (cnt2 < 3) ? cnt2 + 1 : 3;
            mem_slot.valid = 0; mem_slot.branch = 0;
            mem_slot.bne = 0; mem_slot.jump = 0;
        end else if (!stall) begin
            mem_slot = ins;
        end
        e.valid  = mem_slot.valid;
        e.pc     = mem_slot.pc;
        e.pcsrc  = redirects(mem_slot);
        e.target = dest(mem_slot);
        e.cnt16  = cnt16;
        e.cnt2   = cnt2;
        sb_q.push_back(e);
        @(negedge Clk);
    endtask

    // Monitor: once per cycle, after the outputs settle, compare them against
    // the oldest queued expectation.
    initial begin
        expect_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("mem_valid", mem_valid, e.valid);
                checkOutput("mem_pc", mem_pc, e.pc);
                checkOutput("mem_pcsrc", mem_pcsrc, e.pcsrc);
                checkOutput("target", mem_target, e.target);
                checkOutput("flush_ifid", flush_ifid, e.pcsrc);
                checkOutput("flush_idex", flush_idex, e.pcsrc);
                checkOutput("count16", redirect_count, e.cnt16);
                checkOutput("count2", s_redirect_count, e.cnt2);
                checkOutput("small_pcsrc", s_mem_pcsrc, e.pcsrc);
            end
        end
    end

    initial begin
        instr_t nop, ins;
        nop = mk(1, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
        Rst = 1'b1; Stall = 1'b0;
        EX_Valid = 0; EX_Branch = 0; EX_Bne = 0; EX_Jump = 0; EX_Zero = 0;
        EX_PC = '0; EX_Btarg = '0; EX_Jtarg = '0;
        modelReset();
        #7;
        checkOutput("rst_valid", mem_valid, 0);
        checkOutput("rst_pc", mem_pc, 0);
        checkOutput("rst_pcsrc", mem_pcsrc, 0);
        checkOutput("rst_target", mem_target, 0);
        checkOutput("rst_flush", {flush_ifid, flush_idex}, 0);
        checkOutput("rst_count", redirect_count, 0);
        @(negedge Clk);
        Rst = 1'b0;

        // Build up a nonzero count, then reset while a redirect is in flight.
        applyStimulus(mk(1, 0, 0, 1, 0, 32'h100, 32'h0, 32'h0000_0800), 0);
        applyStimulus(nop, 0);
        applyStimulus(mk(1, 1, 0, 0, 1, 32'h104, 32'h0000_0040, 32'h0), 0);
        #2 Rst = 1'b1;
        #1;
        checkOutput("midrst_pcsrc", mem_pcsrc, 0);
        checkOutput("midrst_flush", flush_ifid, 0);
        checkOutput("midrst_count", redirect_count, 0);
        checkOutput("midrst_valid", mem_valid, 0);
        EX_Valid = 0; EX_Branch = 0; EX_Bne = 0; EX_Jump = 0; EX_Zero = 0;
        modelReset();
        @(negedge Clk);
        Rst = 1'b0;

        // Five jumps with ordinary instructions between them. The 2-bit
        // counter saturates.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(mk(1, 0, 0, 1, 0, 32'h200 + k * 8, 32'h0, 32'h0000_0400 + k * 4), 0);
            applyStimulus(nop, 0);
            applyStimulus(nop, 0);
        end

        // Taken beq, then a bne that is not taken, then a taken bne with an
        // unaligned target.
        applyStimulus(mk(1, 1, 0, 0, 1, 32'h300, 32'h0000_0040, 32'h0), 0);
        applyStimulus(nop, 0);
        applyStimulus(nop, 0);
        applyStimulus(mk(1, 0, 1, 0, 1, 32'h304, 32'h0000_0500, 32'h0), 0);
        applyStimulus(nop, 0);
        applyStimulus(mk(1, 0, 1, 0, 0, 32'h308, 32'h0000_0103, 32'h0), 0);
        applyStimulus(nop, 0);
        // Jump wins over branch. A bubble with a stale jump bit does nothing.
        applyStimulus(mk(1, 1, 0, 1, 1, 32'h30C, 32'h0000_0010, 32'h0040_0000), 0);
        applyStimulus(nop, 0);
        applyStimulus(mk(0, 0, 0, 1, 0, 32'h310, 32'h0, 32'h0000_0900), 0);
        applyStimulus(nop, 0);
        // A redirect during a stall still bubbles. A not-taken branch is held
        // through a 3-cycle stall.
        applyStimulus(mk(1, 1, 0, 0, 1, 32'h314, 32'h0000_0a00, 32'h0), 0);
        applyStimulus(nop, 1);
        applyStimulus(nop, 0);
        applyStimulus(mk(1, 1, 0, 0, 0, 32'h318, 32'h0000_0b00, 32'h0), 0);
        for (int k = 0; k < 3; k++) applyStimulus(nop, 1);
        applyStimulus(nop, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int kind;
            ins.valid  = ($urandom_range(0, 9) != 0);
            kind       = $urandom_range(0, 5);
            ins.branch = (kind == 1) || (kind == 4) || ((kind == 5) && $urandom_range(0, 1) == 1);
            ins.bne    = (kind == 2) || ((kind == 5) && $urandom_range(0, 1) == 1);
            ins.jump   = (kind == 3) || (kind == 4) || ((kind == 5) && $urandom_range(0, 1) == 1);
            ins.zero   = $urandom_range(0, 1) == 1;
            ins.pc     = $urandom() & 32'hFFFF_FFFC;
            ins.btarg  = $urandom();
            ins.jtarg  = $urandom();
            applyStimulus(ins, $urandom_range(0, 3) == 0);
        end

        checkOutput("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
